boson_video_gen: RTL

BOSON_VIDEO_GEN -- requirements
Module: boson_video_gen

---
 rtl/boson_video_pkg.sv | 42 ++++
 rtl/boson_video_timing.sv | 61 ++++++
 rtl/boson_video_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/boson_video_pkg.sv
// Shared encodings, timing-decode struct and default timing for the video pattern generator.
// Latency: none (declarations only).
// Backpressure: none.
package boson_video_pkg;

  localparam int DEF_H_TOTAL  = 1711;
  localparam int DEF_V_TOTAL  = 263;
  localparam int DEF_H_SYNC   = 7;
  localparam int DEF_V_SYNC   = 7;
  localparam int DEF_H_START  = 693;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_START  = 7;
  localparam int DEF_V_ACTIVE = 256;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Combinational decode of the current counter position.
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic active;
    logic sof;
    logic eof;
  } tdec_t;

  // Counter width able to hold every value 0..n (n itself is needed for window-end compares).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/boson_video_timing.sv
// Line/frame counters with sync and active-window decode.
// Latency: decode is combinational from the counter registers.
// Backpressure: none; counters advance every clock while run is high, held at 0 otherwise.
module boson_video_timing
  import boson_video_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int H_START  = DEF_H_START,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_START  = DEF_V_START,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int HW       = cnt_w(H_TOTAL),
  parameter int VW       = cnt_w(V_TOTAL)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output tdec_t         dec
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
  localparam logic [HW-1:0] H_BEG    = HW'(H_START);
  localparam logic [HW-1:0] H_END    = HW'(H_START + H_ACTIVE);
  localparam logic [VW-1:0] V_BEG    = VW'(V_START);
  localparam logic [VW-1:0] V_END    = VW'(V_START + V_ACTIVE);

  // Raster position: column wraps into the next line, line wraps into the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Sync and window decode; hsync is suppressed for the whole vertical sync interval.
  always_comb begin
    dec        = '0;
    dec.vsync  = (v_cnt >= V_SYNC_C);
    dec.hsync  = !(dec.vsync && (h_cnt < H_SYNC_C));
    dec.active = (h_cnt >= H_BEG) && (h_cnt < H_END) && (v_cnt >= V_BEG) && (v_cnt < V_END);
    dec.sof    = (h_cnt == '0) && (v_cnt == '0);
    dec.eof    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/boson_video_gen.sv
// Test-pattern video source (INCR/HRAMP/CHECK/CONST) with sync, valid and frame markers; optional
// frame counter stamped on each frame's first pixel when BOSON_VIDEO_GEN_FRAMECNT_EN is defined.
// Latency: outputs registered, one clock after the counter state. Backpressure: none (free-running).
module boson_video_gen
  import boson_video_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int H_START  = DEF_H_START,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_START  = DEF_V_START,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic [DATA_W-1:0] dq,
  output logic              vsync,
  output logic              hsync,
  output logic              valid,
  output logic              frame_start,
`ifdef BOSON_VIDEO_GEN_FRAMECNT_EN
  output logic [DATA_W-1:0] frame_cnt,
`endif
  output logic              busy
);

  localparam int HW = cnt_w(H_TOTAL);
  localparam int VW = cnt_w(V_TOTAL);

  if (H_START + H_ACTIVE > H_TOTAL) begin : g_bad_h
    $error("boson_video_gen: H_START + H_ACTIVE exceeds H_TOTAL");
  end
  if (V_START + V_ACTIVE > V_TOTAL) begin : g_bad_v
    $error("boson_video_gen: V_START + V_ACTIVE exceeds V_TOTAL");
  end
  if (DATA_W < 8 || DATA_W > 32) begin : g_bad_w
    $error("boson_video_gen: DATA_W must be 8..32");
  end

  state_e            state_q, state_d;
  logic              run;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  tdec_t             dec;
  mode_e             mode_q, eff_mode;
  logic [DATA_W-1:0] const_q, eff_const;
  logic [DATA_W-1:0] idx_q, cur_idx, nxt_idx;
  logic [DATA_W-1:0] col, row, pat, pix;

  assign run = (state_q != ST_IDLE);

  boson_video_timing #(
    .H_TOTAL (H_TOTAL),  .V_TOTAL (V_TOTAL),
    .H_SYNC  (H_SYNC),   .V_SYNC  (V_SYNC),
    .H_START (H_START),  .H_ACTIVE(H_ACTIVE),
    .V_START (V_START),  .V_ACTIVE(V_ACTIVE),
    .HW      (HW),       .VW      (VW)
  ) u_timing (
    .clk   (clk),
    .resetn(resetn),
    .run   (run),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .dec   (dec)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Run control: dropping enable lets the frame finish; the last clock decides stop or continue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = dec.eof ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable)       state_d = ST_RUN;
        else if (dec.eof) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef BOSON_VIDEO_GEN_FRAMECNT_EN
  logic [DATA_W-1:0] fcnt_q;
  logic              seen_q;

  // Frames started since reset, and whether this frame has produced a valid pixel yet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fcnt_q <= '0;
      seen_q <= 1'b0;
    end else if (run) begin
      if (dec.sof) fcnt_q <= fcnt_q + DATA_W'(1);
      seen_q <= (dec.sof ? 1'b0 : seen_q) | dec.active;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

  // Pattern select; the frame's first clock uses the live mode/const since that is when they latch.
  always_comb begin
    eff_mode  = dec.sof ? mode_e'(mode) : mode_q;
    eff_const = dec.sof ? const_val : const_q;
    cur_idx   = dec.sof ? '0 : idx_q;
    nxt_idx   = dec.active ? cur_idx + DATA_W'(1) : cur_idx;
    col       = DATA_W'(32'(h_cnt) - 32'(H_START));
    row       = DATA_W'(32'(v_cnt) - 32'(V_START));
    pat       = '0;
    case (eff_mode)
      MODE_INCR:  pat = nxt_idx;
      MODE_HRAMP: pat = col;
      MODE_CHECK: pat = (((col ^ row) & DATA_W'(8)) != '0) ? '1 : '0;
      default:    pat = eff_const;
    endcase
`ifdef BOSON_VIDEO_GEN_FRAMECNT_EN
    // fcnt_q has already counted this frame unless we are on its very first clock.
    if (!(dec.sof ? 1'b0 : seen_q)) pat = dec.sof ? fcnt_q : fcnt_q - DATA_W'(1);
`endif
    pix = dec.active ? pat : '0;
  end

  // Per-frame latches of mode/const and the running pixel index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= MODE_INCR;
      const_q <= '0;
      idx_q   <= '0;
    end else if (!run) begin
      idx_q <= '0;
    end else begin
      if (dec.sof) begin
        mode_q  <= mode_e'(mode);
        const_q <= const_val;
      end
      idx_q <= nxt_idx;
    end
  end

  // Output stage: idle values outside a frame, decoded raster inside one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn || !run) begin
      dq          <= '0;
      valid       <= 1'b0;
      vsync       <= 1'b0;
      hsync       <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dq          <= pix;
      valid       <= dec.active;
      vsync       <= dec.vsync;
      hsync       <= dec.hsync;
      frame_start <= dec.sof;
      busy        <= 1'b1;
    end
  end

endmodule
